// File: rtl/tone_pkg.sv
// Shared state encoding, REST code and pitch table for the tone sequencer.
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [5:0] REST_IDX    = 6'd63;
    localparam int         TABLE_NOTES = 28;

    // Chromatic C4..D#6, equal temperament rounded to whole Hz
    function automatic int unsigned pitch_hz(input logic [5:0] idx);
        case (idx)
            6'd0:    return 262;
            6'd1:    return 277;
            6'd2:    return 294;
            6'd3:    return 311;
            6'd4:    return 330;
            6'd5:    return 349;
            6'd6:    return 370;
            6'd7:    return 392;
            6'd8:    return 415;
            6'd9:    return 440;
            6'd10:   return 466;
            6'd11:   return 494;
            6'd12:   return 523;
            6'd13:   return 554;
            6'd14:   return 587;
            6'd15:   return 622;
            6'd16:   return 659;
            6'd17:   return 698;
            6'd18:   return 740;
            6'd19:   return 784;
            6'd20:   return 831;
            6'd21:   return 880;
            6'd22:   return 932;
            6'd23:   return 988;
            6'd24:   return 1047;
            6'd25:   return 1109;
            6'd26:   return 1175;
            6'd27:   return 1245;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] half_period(input logic [5:0] idx, input int unsigned clk_hz);
        int unsigned f;
        f = pitch_hz(idx);
        if (f == 0) return 32'd0;
        return 32'(clk_hz / (2 * f));
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running down-counter producing a one-cycle tick every DIV clocks.
// A clear reloads the count so the first tick lands exactly DIV cycles later.
module tick_divider #(
    parameter int unsigned DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == '0)) begin
            r_cnt <= LOAD;
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/tone_sequencer.sv
// Timed note player: handshake-accepted notes become a 50% square wave for
// note_dur ms, followed by a fixed silent gap and a one-cycle note_done pulse.
//
// state | meaning
// IDLE  | waiting for a request, note_ready high
// PLAY  | tone (or silence for REST/invalid) for note_dur ms
// GAP   | articulation silence for GAP_MS ms
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned NUM_NOTES = 28,
    parameter int          DUR_W     = 12,
    parameter int unsigned GAP_MS    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [5:0]       note_idx,
    input  logic [DUR_W-1:0] note_dur,
    input  logic             stop,
    output logic             sound,
    output logic             busy,
    output logic             note_done
);

    localparam int unsigned      MS_DIV   = CLK_HZ / 1000;
    localparam int               MS_W     = (DUR_W > 16) ? DUR_W : 16;
    localparam logic [MS_W-1:0]  GAP_LOAD = MS_W'(GAP_MS);

    state_t            r_state, w_state_nxt;
    logic              w_accept, w_done_nxt, w_clear, w_tick;
    logic [MS_W-1:0]   r_ms;
    logic [31:0]       r_hp, r_hp_cnt;
    logic              r_sound, r_busy, r_ready, r_done;
    logic [31:0]       w_hp_tab [64];

    // Constant half-period per index; out-of-range indices and REST stay silent
    for (genvar g = 0; g < 64; g++) begin : g_hp
        if (g < NUM_NOTES) begin : g_note
            assign w_hp_tab[g] = half_period(6'(g), CLK_HZ);
        end else begin : g_rest
            assign w_hp_tab[g] = 32'd0;
        end
    end

    tick_divider #(.DIV(MS_DIV)) u_ms_tick (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (note_valid && !stop) begin
                    w_accept = 1'b1;
                    if (note_dur != '0) begin
                        w_state_nxt = PLAY;
                    end else if (GAP_MS != 0) begin
                        w_state_nxt = GAP;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_tick && (r_ms == MS_W'(1))) begin
                    if (GAP_MS != 0) begin
                        w_state_nxt = GAP;
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_tick && (r_ms == MS_W'(1))) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Restart the ms phase on every entry into a timed state
    assign w_clear = (w_state_nxt != r_state) && (w_state_nxt != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms <= '0;
        end else if ((w_state_nxt == PLAY) && (r_state != PLAY)) begin
            r_ms <= MS_W'(note_dur);
        end else if ((w_state_nxt == GAP) && (r_state != GAP)) begin
            r_ms <= GAP_LOAD;
        end else if ((r_state != IDLE) && w_tick) begin
            r_ms <= r_ms - MS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hp     <= '0;
            r_hp_cnt <= '0;
            r_sound  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hp <= w_hp_tab[note_idx];
            end
            if ((w_state_nxt != PLAY) || (r_state != PLAY) || (r_hp == '0)) begin
                r_hp_cnt <= '0;
                r_sound  <= 1'b0;
            end else if (r_hp_cnt == (r_hp - 32'd1)) begin
                r_hp_cnt <= '0;
                r_sound  <= ~r_sound;
            end else begin
                r_hp_cnt <= r_hp_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_busy  <= (w_state_nxt != IDLE);
            r_ready <= (w_state_nxt == IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign note_ready = r_ready;
    assign busy       = r_busy;
    assign sound      = r_sound;
    assign note_done  = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: output waveform predicted per cycle from note
// frequency, duration and gap arithmetic, with directed and random notes.
module tb_tone_sequencer;

    localparam int unsigned CLK_HZ  = 1_000_000;
    localparam int          MS_CYC  = 1000;
    localparam int          GAP_CYC = 2 * MS_CYC;

    logic        clk = 1'b0;
    logic        reset;
    logic        note_valid;
    logic        note_ready;
    logic [5:0]  note_idx;
    logic [11:0] note_dur;
    logic        stop;
    logic        sound;
    logic        busy;
    logic        note_done;
    logic [3:0]  obs;

    int n_vec = 0;
    int n_err = 0;

    int freq_hz [28] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494,
                         523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988,
                         1047, 1109, 1175, 1245};

    tone_sequencer #(
        .CLK_HZ    (CLK_HZ),
        .NUM_NOTES (28),
        .DUR_W     (12),
        .GAP_MS    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_idx   (note_idx),
        .note_dur   (note_dur),
        .stop       (stop),
        .sound      (sound),
        .busy       (busy),
        .note_done  (note_done)
    );

    always #5 clk = ~clk;

    assign obs = {busy, note_ready, sound, note_done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_hp(input int idx);
        if (idx < 28) return int'(CLK_HZ) / (2 * freq_hz[idx]);
        return 0;
    endfunction

    // {busy, ready, sound, done} k cycles after the accepting edge
    function automatic logic [3:0] ref_outs(input int k, input int hp, input int t_play, input int t_total);
        logic s;
        if (k < t_total) begin
            s = (k < t_play && hp != 0) ? (((k / hp) % 2) == 1) : 1'b0;
            return {1'b1, 1'b0, s, 1'b0};
        end
        if (k == t_total) return 4'b0101;
        return 4'b0100;
    endfunction

    // Call just after the accepting edge; optionally keeps the next request waiting
    task automatic track(input int idx, input int dur, input bit hold,
                         input int nidx, input int ndur, input string name);
        int hp      = ref_hp(idx);
        int t_play  = dur * MS_CYC;
        int t_total = t_play + GAP_CYC;
        int last    = hold ? t_total : t_total + 1;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            if (k == 0) begin
                note_valid = hold;
                note_idx   = 6'(nidx);
                note_dur   = 12'(ndur);
            end
            check($sformatf("%s k=%0d", name, k), 32'(obs), 32'(ref_outs(k, hp, t_play, t_total)));
        end
    endtask

    task automatic send(input int idx, input int dur, input string name);
        @(negedge clk);
        check({name, " ready"}, 32'(note_ready), 32'd1);
        note_valid = 1'b1;
        note_idx   = 6'(idx);
        note_dur   = 12'(dur);
        @(posedge clk);
        track(idx, dur, 1'b0, 0, 0, name);
    endtask

    initial begin
        int hp;
        int quiet;
        int idx;
        int dur;

        reset      = 1'b1;
        note_valid = 1'b0;
        note_idx   = '0;
        note_dur   = '0;
        stop       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset held", 32'(obs), 32'h4);
        reset = 1'b0;
        @(negedge clk);
        check("reset released", 32'(obs), 32'h4);

        send(9, 5, "a4");

        @(negedge clk);
        note_valid = 1'b1;
        note_idx   = 6'd0;
        note_dur   = 12'd2;
        @(posedge clk);
        track(0, 2, 1'b1, 12, 2, "b2b c4");
        @(posedge clk);
        track(12, 2, 1'b0, 0, 0, "b2b c5");

        send(63, 3, "rest");
        send(40, 3, "invalid");
        send(9, 0, "dur0");

        // stop 1500 cycles into a note
        @(negedge clk);
        note_valid = 1'b1;
        note_idx   = 6'd5;
        note_dur   = 12'd4;
        @(posedge clk);
        hp = ref_hp(5);
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if (k == 0) note_valid = 1'b0;
            check($sformatf("stop play k=%0d", k), 32'(obs), 32'(ref_outs(k, hp, 4000, 6000)));
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop to idle", 32'(obs), 32'h4);
        stop       = 1'b1;
        note_valid = 1'b1;
        note_idx   = 6'd9;
        note_dur   = 12'd1;
        @(negedge clk);
        stop       = 1'b0;
        note_valid = 1'b0;
        check("stop blocks accept", 32'(obs), 32'h4);
        quiet = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (obs != 4'b0100) quiet++;
        end
        check("stop no activity", 32'(quiet), 32'd0);

        // asynchronous reset while the tone is high
        @(negedge clk);
        note_valid = 1'b1;
        note_idx   = 6'd9;
        note_dur   = 12'd3;
        @(posedge clk);
        hp = ref_hp(9);
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (k == 0) note_valid = 1'b0;
            check($sformatf("pre-reset k=%0d", k), 32'(obs), 32'(ref_outs(k, hp, 3000, 5000)));
        end
        #2 reset = 1'b1;
        #1 check("async reset", 32'(obs), 32'h4);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset after play", 32'(obs), 32'h4);
        send(12, 1, "after reset");

        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 5) == 0) idx = 63;
            else if ($urandom_range(0, 5) == 0) idx = int'($urandom_range(28, 62));
            else idx = int'($urandom_range(0, 27));
            dur = int'($urandom_range(0, 2));
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
            send(idx, dur, $sformatf("rand%0d idx=%0d dur=%0d", r, idx, dur));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
